// File: rtl/prog_counter.sv
// prog_counter: programmable up/down counter with wrap, saturate and one-shot modes plus tc/ovf flags.
module prog_counter #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             start,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy,
    output logic             ovf
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]       state, state_n;
    logic             ldir, ldir_n;
    logic [WIDTH-1:0] out_n, term, step_val;
    logic             tc_n, ovf_set, run, os, edir, at_t, launch;
    // While running, the direction captured at launch governs; one-shot semantics persist until DONE.
    assign run      = state == RUN;
    assign os       = run || mode == 2'd2;
    assign edir     = run ? ldir : dir;
    assign term     = edir ? limit : '0;
    assign at_t     = out == term;
    assign step_val = edir ? out + 1'b1 : out - 1'b1;
    assign launch   = start && mode == 2'd2 && !run;
    assign busy     = run;
    always_comb begin
        out_n   = out;
        tc_n    = 1'b0;
        state_n = os ? state : IDLE;
        ldir_n  = ldir;
        ovf_set = 1'b0;
        if (clr) begin
            out_n   = RST_VAL;
            state_n = IDLE;
        end else if (load) begin
            out_n = load_val;
        end else if (launch) begin
            state_n = RUN;
            ldir_n  = dir;
            out_n   = dir ? '0 : limit;
        end else if (en && os) begin
            if (run) begin
                out_n   = at_t ? out : step_val;
                tc_n    = !at_t && step_val == term;
                state_n = (at_t || step_val == term) ? DONE : RUN;
            end
        end else if (en) begin
            out_n   = !at_t ? step_val : (mode == 2'd1 ? out : (edir ? '0 : limit));
            tc_n    = !at_t && step_val == term;
            ovf_set = at_t;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= RST_VAL;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            state <= IDLE;
            ldir  <= 1'b1;
        end else begin
            out   <= out_n;
            tc    <= tc_n;
            ovf   <= ovf_set || (ovf && !ovf_clr);
            state <= state_n;
            ldir  <= ldir_n;
        end
    end
endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: directed self-checking bench for prog_counter at WIDTH=8, RST_VAL=0.
module tb_prog_counter;
    logic       clk = 0, rst_n = 0, en = 0, clr = 0, load = 0, dir = 1, start = 0, ovf_clr = 0;
    logic [7:0] load_val = 0, limit = 5, out;
    logic [1:0] mode = 0;
    logic       tc, busy, ovf;
    int total = 0, bad = 0;

    prog_counter #(.WIDTH(8), .RST_VAL(8'd0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .dir(dir), .mode(mode), .limit(limit), .start(start), .ovf_clr(ovf_clr),
        .out(out), .tc(tc), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk4(input string tag, input int eo, input int et, input int eb, input int ev);
        chk({tag, ".out"}, 32'(out), 32'(eo));
        chk({tag, ".tc"}, 32'(tc), 32'(et));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".ovf"}, 32'(ovf), 32'(ev));
    endtask

    initial begin
        int up_o[7]  = '{1, 2, 3, 4, 5, 0, 1};
        int dw_o[4]  = '{1, 0, 3, 2};
        int sat_o[4] = '{1, 0, 0, 0};
        #12;
        chk4("reset", 0, 0, 0, 0);
        rst_n = 1;
        en = 1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk4($sformatf("up%0d", i), up_o[i], up_o[i] == 5, 0, i >= 5);
        end
        // down wrap
        en = 0; limit = 3; dir = 0; load = 1; load_val = 2; ovf_clr = 1;
        tick();
        chk4("dload", 2, 0, 0, 0);
        load = 0; ovf_clr = 0; en = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk4($sformatf("dwrap%0d", i), dw_o[i], i == 1, 0, i >= 2);
        end
        // down saturate
        en = 0; mode = 1; load = 1; ovf_clr = 1;
        tick();
        chk4("sload", 2, 0, 0, 0);
        load = 0; ovf_clr = 0; en = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk4($sformatf("sat%0d", i), sat_o[i], i == 1, 0, i >= 2);
        end
        // one-shot up to 4, dir change during RUN must be ignored
        en = 0; mode = 2; dir = 1; limit = 4; start = 1; ovf_clr = 1;
        tick();
        chk4("os_launch", 0, 0, 1, 0);
        start = 0; ovf_clr = 0; en = 1; dir = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk4($sformatf("os%0d", i), i, i == 4, i != 4, 0);
        end
        for (int i = 0; i < 10; i++) tick();
        chk4("os_hold", 4, 0, 0, 0);
        dir = 1; start = 1;
        tick();
        chk4("os_relaunch", 0, 0, 1, 0);
        start = 0;
        tick();
        tick();
        chk4("os_at2", 2, 0, 1, 0);
        clr = 1; load = 1; load_val = 7;
        tick();
        chk4("prio_clr", 0, 0, 0, 0);
        clr = 0; load = 0; start = 1;
        tick();
        start = 0;
        tick();
        chk4("os_run1", 1, 0, 1, 0);
        en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk4($sformatf("pause%0d", i), 1, 0, 1, 0);
        end
        en = 1;
        tick();
        chk4("resume", 2, 0, 1, 0);
        load = 1; load_val = 3;
        tick();
        chk4("os_load", 3, 0, 1, 0);
        load = 0;
        tick();
        chk4("os_done", 4, 1, 0, 0);
        // full-range wrap and ovf set-wins
        en = 0; mode = 0; limit = 255; load = 1; load_val = 254;
        tick();
        chk4("fr_load", 254, 0, 0, 0);
        load = 0; en = 1;
        tick();
        chk4("fr255", 255, 1, 0, 0);
        ovf_clr = 1;
        tick();
        chk4("fr_wrap", 0, 0, 0, 1);
        en = 0;
        tick();
        chk4("ovf_clr", 0, 0, 0, 0);
        ovf_clr = 0;
        // limit 0 counting up: stuck at 0, ovf on each step, no tc
        limit = 0; en = 1;
        tick();
        chk4("lim0a", 0, 0, 0, 1);
        tick();
        chk4("lim0b", 0, 0, 0, 1);
        // async reset mid one-shot
        en = 0; mode = 2; limit = 10; start = 1; ovf_clr = 1;
        tick();
        start = 0; ovf_clr = 0; en = 1;
        tick(); tick(); tick();
        chk4("pre_rst", 3, 0, 1, 0);
        #2 rst_n = 0;
        #1;
        chk4("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1; mode = 0;
        tick();
        chk4("post_rst1", 1, 0, 0, 0);
        tick();
        chk4("post_rst2", 2, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
